// File: rtl/pe_result_drain.sv
// Drain stage for pe_block: captures result vectors into a two-slot ping-pong buffer and
// streams each one out as BLOCK_NUM beats of ARRAY_NUM bytes over valid/ready.
module pe_result_drain #(
  parameter int unsigned ARRAY_NUM = 3,
  parameter int unsigned BLOCK_NUM = 3,
  localparam int unsigned IdxW  = (BLOCK_NUM > 1) ? $clog2(BLOCK_NUM) : 1,
  localparam int unsigned BeatW = 8 * ARRAY_NUM,
  localparam int unsigned VecW  = BeatW * BLOCK_NUM
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iCapture,
  input  logic [VecW-1:0]  iResult,
  input  logic             iCfsRelu,
  input  logic             iClearOverflow,
  output logic             oCaptureReady,
  output logic             oOverflow,
  output logic [BeatW-1:0] oData,
  output logic             oValid,
  input  logic             iReady,
  output logic             oLast,
  output logic [IdxW-1:0]  oBlockIdx
);

  localparam logic [IdxW-1:0] LastIdx = IdxW'(BLOCK_NUM - 1);

  logic [VecW-1:0] slot_q [2];
  logic [VecW-1:0] slot_d [2];
  logic            wp_q, wp_d;
  logic            rp_q, rp_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0] beat_q, beat_d;
  logic            ovf_q, ovf_d;

  logic            accept, drop, xfer, free_slot;
  logic [VecW-1:0] relu_vec;
  logic [BeatW-1:0] head_beat;

  // Capture readiness and output valid derive from registered occupancy only.
  assign oCaptureReady = (cnt_q != 2'd2);
  assign oValid        = (cnt_q != 2'd0);
  assign oBlockIdx     = beat_q;
  assign oLast         = oValid && (beat_q == LastIdx);
  assign oOverflow     = ovf_q;
  assign oData         = head_beat;

  assign accept    = iCapture && oCaptureReady;
  assign drop      = iCapture && !oCaptureReady;
  assign xfer      = oValid && iReady;
  assign free_slot = xfer && (beat_q == LastIdx);

  always_comb begin
    relu_vec = iResult;
    if (iCfsRelu) begin
      for (int unsigned i = 0; i < VecW / 8; i++) begin
        if (iResult[8*i+7]) relu_vec[8*i +: 8] = 8'h00;
      end
    end
  end

  always_comb begin
    head_beat = '0;
    for (int unsigned b = 0; b < BLOCK_NUM; b++) begin
      if (beat_q == IdxW'(b)) head_beat = slot_q[rp_q][b*BeatW +: BeatW];
    end
  end

  always_comb begin
    slot_d[0] = slot_q[0];
    slot_d[1] = slot_q[1];
    wp_d      = wp_q;
    rp_d      = rp_q;
    beat_d    = beat_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q + {1'b0, accept} - {1'b0, free_slot};

    if (accept) begin
      slot_d[wp_q] = relu_vec;
      wp_d         = ~wp_q;
    end

    if (xfer) begin
      if (free_slot) begin
        beat_d = '0;
        rp_d   = ~rp_q;
      end else begin
        beat_d = beat_q + IdxW'(1);
      end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (iClearOverflow) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      wp_q      <= 1'b0;
      rp_q      <= 1'b0;
      cnt_q     <= 2'd0;
      beat_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      slot_q[0] <= slot_d[0];
      slot_q[1] <= slot_d[1];
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      beat_q    <= beat_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pe_result_drain.sv
// Scoreboard bench for pe_result_drain: expected beats are queued at capture time and
// compared against every cycle the DUT presents a valid beat.
module tb_pe_result_drain;

  localparam int unsigned A     = 3;
  localparam int unsigned B     = 3;
  localparam int unsigned BeatW = 8 * A;
  localparam int unsigned VecW  = BeatW * B;

  typedef struct {
    logic [BeatW-1:0] data;
    logic [1:0]       idx;
    logic             last;
  } beat_t;

  logic             iClk = 1'b0;
  logic             iRst;
  logic             iCapture;
  logic [VecW-1:0]  iResult;
  logic             iCfsRelu;
  logic             iClearOverflow;
  logic             oCaptureReady;
  logic             oOverflow;
  logic [BeatW-1:0] oData;
  logic             oValid;
  logic             iReady;
  logic             oLast;
  logic [1:0]       oBlockIdx;

  beat_t sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    hs_cnt  = 0;

  pe_result_drain #(.ARRAY_NUM(A), .BLOCK_NUM(B)) dut (
    .iClk           (iClk),
    .iRst           (iRst),
    .iCapture       (iCapture),
    .iResult        (iResult),
    .iCfsRelu       (iCfsRelu),
    .iClearOverflow (iClearOverflow),
    .oCaptureReady  (oCaptureReady),
    .oOverflow      (oOverflow),
    .oData          (oData),
    .oValid         (oValid),
    .iReady         (iReady),
    .oLast          (oLast),
    .oBlockIdx      (oBlockIdx)
  );

  always #5 iClk = ~iClk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [VecW-1:0] make_vec(input int base);
    logic [VecW-1:0] v;
    for (int i = 0; i < int'(VecW / 8); i++) v[8*i +: 8] = 8'(base + i);
    return v;
  endfunction

  task automatic push_expected(input logic [VecW-1:0] v, input logic relu);
    beat_t e;
    logic [7:0] by;
    for (int b = 0; b < int'(B); b++) begin
      for (int i = 0; i < int'(A); i++) begin
        by = v[(b*int'(A) + i)*8 +: 8];
        e.data[8*i +: 8] = (relu && by[7]) ? 8'h00 : by;
      end
      e.idx  = 2'(b);
      e.last = (b == int'(B) - 1);
      sb.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Drives a capture strobe across one edge; queues its beats if the bench expects acceptance.
  task automatic capture(input logic [VecW-1:0] v, input logic relu, input logic expect_acc);
    iCapture = 1'b1;
    iResult  = v;
    iCfsRelu = relu;
    if (expect_acc) push_expected(v, relu);
    tick();
    iCapture = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int i;
    for (i = 0; i < 60; i++) begin
      if (sb.size() == 0 && !oValid) break;
      tick();
    end
    if (i == 60) check({tag, "_drain_timeout"}, 64'(sb.size()), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(oValid), 64'(0));
    check({tag, "_last"},  64'(oLast), 64'(0));
    check({tag, "_idx"},   64'(oBlockIdx), 64'(0));
    check({tag, "_data"},  64'(oData), 64'(0));
    check({tag, "_crdy"},  64'(oCaptureReady), 64'(1));
    check({tag, "_ovf"},   64'(oOverflow), 64'(0));
  endtask

  // Monitor: compares the presented beat against the scoreboard head every valid cycle,
  // which also covers stability under stall; pops on handshake.
  always @(negedge iClk) begin
    if (!iRst && oValid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'(oValid), 64'(0));
      end else begin
        check("beat_data", 64'(oData), 64'(sb[0].data));
        check("beat_idx",  64'(oBlockIdx), 64'(sb[0].idx));
        check("beat_last", 64'(oLast), 64'(sb[0].last));
        if (iReady) begin
          void'(sb.pop_front());
          hs_cnt++;
        end
      end
    end
  end

  initial begin
    int hs0;
    logic [VecW-1:0] rv;
    iRst = 1'b1;
    iCapture = 1'b0;
    iResult = '0;
    iCfsRelu = 1'b0;
    iClearOverflow = 1'b0;
    iReady = 1'b1;
    repeat (3) tick();
    check_reset_outputs("rst");
    iRst = 1'b0;
    tick();

    // Single capture, full throughput.
    capture(make_vec(1), 1'b0, 1'b1);
    check("single_latency_valid", 64'(oValid), 64'(1));
    check("single_beat0", 64'(oData), 64'(24'h030201));
    tick();
    check("single_beat1", 64'(oData), 64'(24'h060504));
    tick();
    check("single_beat2_last", 64'(oLast), 64'(1));
    tick();
    check("single_valid_fall", 64'(oValid), 64'(0));
    wait_drain("single");

    // Backpressure: stall 2 cycles, then ready toggles 1,0,1,0,1.
    iReady = 1'b0;
    hs0 = hs_cnt;
    capture(make_vec(1), 1'b0, 1'b1);
    tick();
    check("bp_stall_data", 64'(oData), 64'(24'h030201));
    tick();
    for (int i = 0; i < 5; i++) begin
      iReady = (i % 2 == 0);
      tick();
    end
    iReady = 1'b1;
    check("bp_handshakes", 64'(hs_cnt - hs0), 64'(3));
    check("bp_empty", 64'(oValid), 64'(0));
    wait_drain("bp");

    // Ping-pong: B arrives as A frees its slot; output stays gap-free.
    capture(make_vec(1), 1'b0, 1'b1);
    check("pp_crdy0", 64'(oCaptureReady), 64'(1));
    tick();
    tick();
    capture(make_vec(11), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("pp_contig_valid", 64'(oValid), 64'(1));
      check("pp_crdy", 64'(oCaptureReady), 64'(1));
      tick();
    end
    check("pp_done", 64'(oValid), 64'(0));
    wait_drain("pp");

    // Overflow: three captures while stalled; only A and B survive.
    iReady = 1'b0;
    capture(make_vec(1), 1'b0, 1'b1);
    check("ovf_crdy_after_a", 64'(oCaptureReady), 64'(1));
    capture(make_vec(11), 1'b0, 1'b1);
    check("ovf_crdy_after_b", 64'(oCaptureReady), 64'(0));
    check("ovf_flag_after_b", 64'(oOverflow), 64'(0));
    capture(make_vec(21), 1'b0, 1'b0);
    check("ovf_flag_after_c", 64'(oOverflow), 64'(1));
    iReady = 1'b1;
    wait_drain("ovf");
    check("ovf_sticky", 64'(oOverflow), 64'(1));
    iClearOverflow = 1'b1;
    tick();
    iClearOverflow = 1'b0;
    check("ovf_cleared", 64'(oOverflow), 64'(0));

    // ReLU at capture time, then the same input passed through raw.
    rv = make_vec(1);
    rv[23:0] = 24'hF0807F;
    capture(rv, 1'b1, 1'b1);
    check("relu_on_beat0", 64'(oData), 64'(24'h00007F));
    wait_drain("relu_on");
    capture(rv, 1'b0, 1'b1);
    check("relu_off_beat0", 64'(oData), 64'(24'hF0807F));
    wait_drain("relu_off");

    // Reset mid-drain with B queued behind A.
    capture(make_vec(1), 1'b0, 1'b1);
    capture(make_vec(11), 1'b0, 1'b1);
    check("mid_beat1_idx", 64'(oBlockIdx), 64'(1));
    iRst = 1'b1;
    tick();
    sb.delete();
    check_reset_outputs("midrst");
    iRst = 1'b0;
    tick();
    check("post_rst_idle", 64'(oValid), 64'(0));
    capture(make_vec(31), 1'b0, 1'b1);
    check("post_rst_idx0", 64'(oBlockIdx), 64'(0));
    check("post_rst_beat0", 64'(oData), 64'(24'h21201F));
    wait_drain("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/pe_result_drain.md
# pe_result_drain

Downstream drain stage for `pe_block`. It captures the block's parallel `oResult` vector (BLOCK_NUM × ARRAY_NUM int8 lanes) on a capture strobe and holds up to two result vectors in a ping-pong buffer. It streams each vector out as BLOCK_NUM beats of ARRAY_NUM bytes over a valid/ready interface, with optional ReLU. It decouples the PE array's accumulate/clear cadence from the consumer (writeback or next-layer feeder).

## Interface
- `ARRAY_NUM`, 3: lanes (bytes) per beat; equals PE count per array in `pe_block`.
- `BLOCK_NUM`, 3: beats per captured vector; equals array count in `pe_block`.
- `iClk`  in  1  clock; all logic on rising edge.
- `iRst`  in  1  reset; synchronous and active-high.
- `iCapture`  in  1  one-cycle strobe: `iResult` is final and must be captured.
- `iResult`  in  8*ARRAY_NUM*BLOCK_NUM  result vector from `pe_block.oResult`; block b occupies bits [8*ARRAY_NUM*(b+1)-1 : 8*ARRAY_NUM*b].
- `iCfsRelu`  in  1  config: clamp negative int8 bytes to 0 at capture time.
- `iClearOverflow`  in  1  clears sticky overflow flag.
- `oCaptureReady`  out  1  buffer has a free slot (occupancy < 2).
- `oOverflow`  out  1  sticky: a capture was dropped.
- `oData`  out  8*ARRAY_NUM  current beat: block `oBlockIdx` of the head vector.
- `oValid`  out  1  `oData` is valid.
- `iReady`  in  1  consumer accepts beat when `oValid && iReady`.
- `oLast`  out  1  current beat is the last block (index BLOCK_NUM-1) of the vector.
- `oBlockIdx`  out  $clog2(BLOCK_NUM) (min 1)  block index of current beat.

## Operation
- Storage: two vector slots, write pointer `wp`, read pointer `rp`, occupancy `cnt` (0..2), and beat counter `beat` (0..BLOCK_NUM-1).
- Capture: on an edge with `iCapture=1` and `cnt<2`, write `iResult` into slot `wp`. ReLU is applied per byte if `iCfsRelu=1`: a byte with bit7=1 is stored as 0x00; otherwise it is stored unchanged. Then toggle `wp`.
- Drop: on `iCapture=1` with `cnt==2`, discard the vector. Set `oOverflow=1`. Buffer contents are unchanged.
- Output: `oValid = (cnt!=0)`. `oData` = slot `rp` bytes of block `beat`. `oBlockIdx = beat`. `oLast = oValid && beat==BLOCK_NUM-1`.
- Transfer (`oValid && iReady`): if `beat<BLOCK_NUM-1`, increment `beat`. Otherwise set `beat` to 0, toggle `rp`, and free the slot.
- Occupancy update per edge: `cnt += accept_capture - free_slot`.
- Simultaneous capture and last-beat free when `cnt==2`: the capture is dropped, because `oCaptureReady` was low that cycle. The slot is still freed.
- Simultaneous capture and free when `cnt==1`: `cnt` stays 1. The new vector is queued behind the head, and output continues gap-free.
- Stability: while `oValid && !iReady`, `oData`, `oBlockIdx` and `oLast` hold.
- `iClearOverflow` clears `oOverflow`. A drop in the same cycle wins, so the flag stays 1.
- `iCfsRelu` is sampled per capture. Changing it does not alter already-buffered vectors.

## Timing
- Reset values: `oValid=0`, `oLast=0`, `oBlockIdx=0`, `oData=0`, `oCaptureReady=1`, `oOverflow=0`. Slots, pointers, `cnt` and `beat` are all 0.
- Reset mid-drain discards all buffered data. The next edge after reset deasserts presents reset values.
- Capture-to-valid latency is 1 cycle: capture at edge N gives `oValid=1` after edge N.
- Throughput is 1 beat/cycle with `iReady` held high. Back-to-back captures every BLOCK_NUM cycles sustain continuous output.
- `oCaptureReady` depends only on registered state, with no combinational path from `iReady`. `oValid`/`oData` have no combinational path from `iCapture`/`iResult`.

## Test plan
- Single capture, ARRAY_NUM=BLOCK_NUM=3: `iResult` bytes 1..9 (byte0=1), `iReady=1` -> beats {3,2,1}, {6,5,4}, {9,8,7} on cycles 1–3 after capture. `oBlockIdx` reads 0,1,2. `oLast` is high only on the third beat. `oValid` falls on cycle 4.
- Backpressure: same vector, `iReady` low on cycles 1–2 then toggling 1,0,1,0,1 -> beat {3,2,1} held stable while stalled. Exactly 3 handshakes occur, in order, with no duplicates.
- Ping-pong: captures of vectors A (1..9) then B (11..19) two cycles apart, `iReady=1` -> 6 contiguous beats A0,A1,A2,B0,B1,B2. `oCaptureReady` stays 1 throughout.
- Overflow: `iReady=0`, captures A, B, C on consecutive cycles -> `oCaptureReady=0` after B and `oOverflow=1` after C. Releasing `iReady` drains A then B only. `iClearOverflow` then drops the flag to 0.
- ReLU: `iCfsRelu=1`, block0 bytes {0x7F,0x80,0xF0} -> beat {0x7F,0x00,0x00}. With `iCfsRelu=0` the same input is output unchanged.
- Reset mid-drain: assert `iRst` after beat 1 of A while B is queued -> all outputs at reset values next cycle. A new capture afterwards drains correctly from block 0.
